// File: rtl/ram_rmw_ctrl_pkg.sv
// Shared types and helpers for the RAM read-modify-write front-end.
// The strobe helpers work one byte lane at a time or on a zero-padded strobe, so any data width up to MAX_DBITS is supported.
package ram_rmw_ctrl_pkg;

  localparam int MAX_DBITS = 512;
  localparam int MAX_SBITS = MAX_DBITS / 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } state_e;

  // One byte lane of the merge; the caller instantiates it once per lane.
  function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       strb);
    return strb ? new_byte : old_byte;
  endfunction

  function automatic logic strb_full(input logic [MAX_SBITS-1:0] strb,
                                     input int                   nbytes);
    logic f;
    f = 1'b1;
    for (int k = 0; k < MAX_SBITS; k++) begin
      if ((k < nbytes) && !strb[k]) f = 1'b0;
    end
    return f;
  endfunction

  function automatic logic strb_empty(input logic [MAX_SBITS-1:0] strb);
    return (strb == '0);
  endfunction

endpackage

// File: rtl/ram_rmw_ctrl.sv
// Request front-end for a single-port write-first RAM; partial-strobe writes become read-modify-write.
// Optional RAM clear after reset: RAM_RMW_CTRL_INIT_EN.
//
// state     | meaning
// ST_INIT   | clearing RAM, one address per cycle (RAM_RMW_CTRL_INIT_EN only)
// ST_IDLE   | ready for a request
// ST_ACCESS | address presented; full writes land here
// ST_MERGE  | RAM word available; partial writes land here, result captured
// ST_RESP   | response held until consumed
module ram_rmw_ctrl
  import ram_rmw_ctrl_pkg::*;
#(
  parameter int abits = 12,
  parameter int dbits = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [abits-1:0]   i_req_addr,
  input  logic               i_req_write,
  input  logic [dbits/8-1:0] i_req_wstrb,
  input  logic [dbits-1:0]   i_req_wdata,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [dbits-1:0]   o_resp_rdata,
  output logic [abits-1:0]   o_ram_addr,
  output logic               o_ram_wena,
  output logic [dbits-1:0]   o_ram_wdata,
  input  logic [dbits-1:0]   i_ram_rdata
);

  localparam int SBITS = dbits / 8;

  state_e             state_q, state_d;
  logic [abits-1:0]   addr_q, addr_d;
  logic               write_q, write_d;
  logic [SBITS-1:0]   wstrb_q, wstrb_d;
  logic [dbits-1:0]   wdata_q, wdata_d;
  logic [dbits-1:0]   rdata_q, rdata_d;
`ifdef RAM_RMW_CTRL_INIT_EN
  logic [abits-1:0]   init_cnt_q, init_cnt_d;
`endif

  logic [MAX_SBITS-1:0] strb_pad;
  logic [dbits-1:0]     merged;
  logic                 full_wr, part_wr;

  always_comb begin
    strb_pad = '0;
    strb_pad[SBITS-1:0] = wstrb_q;
  end

  assign full_wr = write_q && strb_full(strb_pad, SBITS);
  assign part_wr = write_q && !strb_full(strb_pad, SBITS) && !strb_empty(strb_pad);

  for (genvar k = 0; k < SBITS; k++) begin : g_lane
    assign merged[8*k +: 8] = strb_merge(i_ram_rdata[8*k +: 8], wdata_q[8*k +: 8], wstrb_q[k]);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
`ifdef RAM_RMW_CTRL_INIT_EN
    init_cnt_d   = init_cnt_q;
`endif
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_ram_addr   = addr_q;
    o_ram_wena   = 1'b0;
    o_ram_wdata  = wdata_q;

    case (state_q)
      ST_INIT: begin
`ifdef RAM_RMW_CTRL_INIT_EN
        o_ram_wena  = 1'b1;
        o_ram_addr  = init_cnt_q;
        o_ram_wdata = '0;
        init_cnt_d  = init_cnt_q + 1'b1;
        if (init_cnt_q == {abits{1'b1}}) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          addr_d  = i_req_addr;
          write_d = i_req_write;
          wstrb_d = i_req_wstrb;
          wdata_d = i_req_wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_ram_wena = full_wr;
        state_d    = ST_MERGE;
      end
      ST_MERGE: begin
        // Full writes read back wdata here thanks to the write-first RAM.
        if (part_wr) begin
          o_ram_wena  = 1'b1;
          o_ram_wdata = merged;
        end
        rdata_d = o_ram_wena ? o_ram_wdata : i_ram_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_resp_rdata = rdata_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
`ifdef RAM_RMW_CTRL_INIT_EN
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
`else
      state_q    <= ST_IDLE;
`endif
      addr_q     <= '0;
      write_q    <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
`ifdef RAM_RMW_CTRL_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      addr_q     <= addr_d;
      write_q    <= write_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Randomized self-checking bench for ram_rmw_ctrl with a write-first RAM model and a word-level reference memory.
module tb_ram_rmw_ctrl;

  localparam int AB = 4;
  localparam int DB = 32;
  localparam int SB = DB / 8;
  localparam int NW = 1 << AB;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AB-1:0] req_addr;
  logic [SB-1:0] req_wstrb;
  logic [DB-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DB-1:0] resp_rdata;
  logic [AB-1:0] ram_addr;
  logic          ram_wena;
  logic [DB-1:0] ram_wdata, ram_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram_rmw_ctrl #(.abits(AB), .dbits(DB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_write (req_write),
    .i_req_wstrb (req_wstrb),
    .i_req_wdata (req_wdata),
    .o_resp_valid(resp_valid),
    .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata),
    .o_ram_addr  (ram_addr),
    .o_ram_wena  (ram_wena),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  function automatic logic [DB-1:0] init_word(input int i);
    return 32'hC0DE0000 | DB'(i * 32'h0000_1357);
  endfunction

  // Write-first single-port RAM with registered output; preloaded while reset is held.
  logic [DB-1:0] ram [NW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) ram[i] <= init_word(i);
      ram_rdata <= '0;
    end else begin
      if (ram_wena) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram_wena ? ram_wdata : ram[ram_addr];
    end
  end

  logic [DB-1:0] ref_mem [NW];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset(input bit check_vals);
    rst = 1'b1;
    @(negedge clk);
    if (check_vals) begin
`ifdef RAM_RMW_CTRL_INIT_EN
      chk("rst_req_ready", req_ready, 0);
      chk("rst_ram_wena", ram_wena, 1);
`else
      chk("rst_req_ready", req_ready, 1);
      chk("rst_ram_wena", ram_wena, 0);
`endif
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
`ifndef RAM_RMW_CTRL_INIT_EN
      chk("rst_ram_addr", ram_addr, 0);
`endif
      chk("rst_ram_wdata", ram_wdata, 0);
    end
    @(negedge clk);
    rst = 1'b0;
`ifdef RAM_RMW_CTRL_INIT_EN
    for (int i = 0; i < NW; i++) begin
      chk("init_pins", {ram_wena, req_ready, 28'(ram_addr), ram_wdata},
                       {1'b1, 1'b0, 28'(i), 32'h0});
      @(negedge clk);
    end
    chk("init_done_ready", req_ready, 1);
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
`else
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
`endif
  endtask

  // Called at a negedge with the controller idle; returns at a negedge, idle again.
  task automatic do_req(input logic [AB-1:0] a, input logic wr, input logic [SB-1:0] strb,
                        input logic [DB-1:0] d, input int hold);
    logic [DB-1:0] old_w, exp_w;
    logic [1:0]    exp_pat, pat;
    logic          full, part;
    old_w = ref_mem[a];
    full  = wr && (strb == '1);
    part  = wr && (strb != '0) && !full;
    exp_w = old_w;
    for (int k = 0; k < SB; k++) if (wr && strb[k]) exp_w[8*k +: 8] = d[8*k +: 8];
    exp_pat = full ? 2'b01 : (part ? 2'b10 : 2'b00);
    if (full || part) ref_mem[a] = exp_w;

    chk("idle_ready", {resp_valid, req_ready}, 2'b01);
    req_valid = 1'b1; req_addr = a; req_write = wr; req_wstrb = strb; req_wdata = d;
    @(posedge clk);
    #1;
    // Keep garbage on the request bus while busy; it must neither be accepted nor reach the RAM.
    req_addr  = AB'($urandom);
    req_write = 1'($urandom);
    req_wstrb = SB'($urandom);
    req_wdata = $urandom;
    pat = 2'b00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      pat[c] = ram_wena;
      chk("busy_handshake", {resp_valid, req_ready}, 2'b00);
      if (ram_wena) chk("ram_write_word", {28'(ram_addr), ram_wdata}, {28'(a), exp_w});
    end
    @(negedge clk);
    chk("write_phase", pat, exp_pat);
    chk("resp_t3", {resp_valid, req_ready, ram_wena}, 3'b100);
    chk("resp_rdata", resp_rdata, exp_w);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("resp_hold", {resp_valid, req_ready, ram_wena, resp_rdata}, {3'b100, exp_w});
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("back_idle", {resp_valid, req_ready}, 2'b01);
    chk("idle_pins", {ram_wena, 28'(ram_addr), ram_wdata}, {1'b0, 28'(a), d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wstrb = '0; req_wdata = '0;
    resp_ready = 1'b0;
    do_reset(1'b1);

    do_req(4'd3, 1'b1, 4'hF, 32'hDEADBEEF, 0);
    do_req(4'd3, 1'b0, 4'h0, 32'h0, 0);
    do_req(4'd3, 1'b1, 4'b0101, 32'h11223344, 0);
    chk("merge_example", ref_mem[3], 32'hDE22BE44);
    do_req(4'd5, 1'b1, 4'h0, 32'hFFFFFFFF, 0);
    do_req(4'd9, 1'b0, 4'hF, 32'h0, 10);

    // Reset dropped during MERGE of a read.
    req_valid = 1'b1; req_addr = 4'd7; req_write = 1'b0; req_wstrb = 4'hF; req_wdata = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_quiet", {resp_valid, ram_wena, req_ready}, 3'b001);
      @(negedge clk);
    end
    do_req(4'd7, 1'b0, 4'h0, 32'h0, 1);
    do_req(4'd7, 1'b1, 4'b1000, 32'hAB000000, 0);

    for (int n = 0; n < 40; n++) begin
      logic [SB-1:0] s;
      case ($urandom_range(0, 3))
        0:       s = 4'hF;
        1:       s = 4'h0;
        default: s = SB'($urandom);
      endcase
      do_req(AB'($urandom), 1'($urandom), s, $urandom, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < NW; i++) do_req(AB'(i), 1'b0, 4'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
